mem_wb_stage: RTL

- Memory/write-back stage. Consumes the ALU/MEM pipeline register outputs and runs the data-cache access for loads and stores.
- Produces the register-file write port (addrD, data_d, is_write) that the decode stage consumes.
- Produces block_pipe_data_cache, which stalls the upstream stages while a cache access is outstanding.
- A per-access timeout counter prevents an unresponsive cache from hanging the pipeline.

---
 rtl/mem_wb_stage.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/mem_wb_stage.sv
// Memory/write-back pipeline stage: retires ALU ops in one cycle, runs data-cache
// loads/stores with a bounded wait, and drives the register-file write port.
module mem_wb_stage #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int VADDR_W = 32,
  parameter int TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wrt_en,
  input  logic [DATA_W-1:0]  alu_result,
  input  logic [DATA_W-1:0]  store_data,
  input  logic [ADDR_W-1:0]  regD_in,
  input  logic               WB_EN_in,
  input  logic               MEM_R_EN_in,
  input  logic               MEM_W_EN_in,
  input  logic               MEM_TO_REG_in,
  output logic               dc_req,
  output logic               dc_we,
  output logic [VADDR_W-1:0] dc_addr,
  output logic [DATA_W-1:0]  dc_wdata,
  input  logic [DATA_W-1:0]  dc_rdata,
  input  logic               dc_ready,
  output logic               block_pipe_data_cache,
  output logic [ADDR_W-1:0]  addrD,
  output logic [DATA_W-1:0]  data_d,
  output logic               is_write,
  output logic               dc_timeout
);

  localparam int CNT_W = $clog2(TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT - 1);

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_ACCESS = 1'b1;

  logic [0:0]         state_q,      state_d;
  logic [CNT_W-1:0]   cnt_q,        cnt_d;
  logic               dc_req_q,     dc_req_d;
  logic               dc_we_q,      dc_we_d;
  logic [VADDR_W-1:0] dc_addr_q,    dc_addr_d;
  logic [DATA_W-1:0]  dc_wdata_q,   dc_wdata_d;
  logic [ADDR_W-1:0]  addrd_q,      addrd_d;
  logic [DATA_W-1:0]  data_d_q,     data_d_d;
  logic               is_write_q,   is_write_d;
  logic               dc_timeout_q, dc_timeout_d;
  logic [ADDR_W-1:0]  cap_dest_q,   cap_dest_d;
  logic               cap_wb_q,     cap_wb_d;
  logic               cap_load_q,   cap_load_d;
  logic               mem_op_s;

  assign mem_op_s = MEM_R_EN_in | MEM_W_EN_in;

  // Next-state and output computation for the IDLE/ACCESS machine
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    dc_req_d     = dc_req_q;
    dc_we_d      = dc_we_q;
    dc_addr_d    = dc_addr_q;
    dc_wdata_d   = dc_wdata_q;
    addrd_d      = addrd_q;
    data_d_d     = data_d_q;
    is_write_d   = 1'b0;
    dc_timeout_d = dc_timeout_q;
    cap_dest_d   = cap_dest_q;
    cap_wb_d     = cap_wb_q;
    cap_load_d   = cap_load_q;

    case (state_q)
      S_IDLE: begin
        if (wrt_en) begin
          if (mem_op_s) begin
            // Both enables set is resolved as a load
            cap_dest_d = regD_in;
            cap_wb_d   = WB_EN_in & MEM_TO_REG_in;
            cap_load_d = MEM_R_EN_in;
            dc_req_d   = 1'b1;
            dc_we_d    = MEM_W_EN_in & ~MEM_R_EN_in;
            dc_addr_d  = VADDR_W'(alu_result);
            dc_wdata_d = store_data;
            cnt_d      = '0;
            state_d    = S_ACCESS;
          end else begin
            addrd_d    = regD_in;
            data_d_d   = alu_result;
            is_write_d = WB_EN_in;
          end
        end else begin
          is_write_d = 1'b0;
        end
      end
      S_ACCESS: begin
        if (dc_ready) begin
          dc_req_d = 1'b0;
          state_d  = S_IDLE;
          if (cap_load_q) begin
            addrd_d    = cap_dest_q;
            data_d_d   = dc_rdata;
            is_write_d = cap_wb_q;
          end else begin
            is_write_d = 1'b0;
          end
        end else if (cnt_q >= CNT_LIMIT) begin
          // Ready at the limit takes the branch above, so only true silence aborts
          dc_req_d     = 1'b0;
          dc_timeout_d = 1'b1;
          state_d      = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        dc_req_d = 1'b0;
        state_d  = S_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      dc_req_q     <= 1'b0;
      dc_we_q      <= 1'b0;
      dc_addr_q    <= '0;
      dc_wdata_q   <= '0;
      addrd_q      <= '0;
      data_d_q     <= '0;
      is_write_q   <= 1'b0;
      dc_timeout_q <= 1'b0;
      cap_dest_q   <= '0;
      cap_wb_q     <= 1'b0;
      cap_load_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      dc_req_q     <= dc_req_d;
      dc_we_q      <= dc_we_d;
      dc_addr_q    <= dc_addr_d;
      dc_wdata_q   <= dc_wdata_d;
      addrd_q      <= addrd_d;
      data_d_q     <= data_d_d;
      is_write_q   <= is_write_d;
      dc_timeout_q <= dc_timeout_d;
      cap_dest_q   <= cap_dest_d;
      cap_wb_q     <= cap_wb_d;
      cap_load_q   <= cap_load_d;
    end
  end

  assign block_pipe_data_cache = (state_q == S_ACCESS);
  assign dc_req     = dc_req_q;
  assign dc_we      = dc_we_q;
  assign dc_addr    = dc_addr_q;
  assign dc_wdata   = dc_wdata_q;
  assign addrD      = addrd_q;
  assign data_d     = data_d_q;
  assign is_write   = is_write_q;
  assign dc_timeout = dc_timeout_q;

endmodule
